multicycle_muldiv_unit: RTL and testbench
=========================================

# multicycle_muldiv_unit

Parametrised multi-cycle RV32M multiply/divide unit that sits beside the single-cycle execute ALU. It accepts one M-extension operation through a valid/ready handshake and runs it on a pipelined multiplier or an iterative radix-2 divider. It returns one result with its destination register through a second valid/ready handshake. The pipeline stalls issue on `in_ready` low and merges `out_*` into the MEM/WB path.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; must be even and ≥ 8.
- `MUL_LATENCY`, 2: multiplier pipeline depth in cycles, range 1..4.

Ports. One clock; reset is synchronous and active-low.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `flush` in 1: kill the in-flight operation and any held result.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept.
- `in_alu_op` in 6: `ALU_OP_MUL` through `ALU_OP_REMU` from `rv32_pkg`.
- `in_rs1` in XLEN: operand A, already forwarded.
- `in_rs2` in XLEN: operand B, already forwarded.
- `in_rd` in 5: destination register.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer takes the result.
- `out_result` out XLEN: result.
- `out_rd` out 5: destination register.
- `out_illegal` out 1: `in_alu_op` was not an M op.
- `busy` out 1: state ≠ IDLE.

## Operation
FSM states: IDLE, MUL, DIV, DONE.
- **IDLE**
  - A transfer happens when `in_valid & in_ready` are both high. Latch the operands, op and rd.
  - MUL/MULH/MULHSU/MULHU → MUL.
  - DIV/DIVU/REM/REMU → DIV.
  - Any other op → DONE with `out_illegal`=1 and result 0.
- **MUL**
  - Full 2·XLEN-bit product. Operand sign extension per op:
    - MULH: signed × signed.
    - MULHSU: signed × unsigned.
    - MULHU: unsigned × unsigned.
  - MUL returns bits [XLEN-1:0]; the other three return bits [2·XLEN-1:XLEN].
  - Counter runs `MUL_LATENCY` cycles, then → DONE.
- **DIV**
  - Restoring radix-2 on magnitudes, one quotient bit per cycle, XLEN iterations, counter `$clog2(XLEN)+1` bits.
  - Signed ops fix up the sign at the end:
    - Quotient is negative iff the operand signs differ.
    - Remainder takes the sign of the dividend.
  - Special cases resolve in one cycle and skip the iterations:
    - Divisor 0: DIV/DIVU give all-ones; REM/REMU give rs1.
    - Signed overflow (rs1 = most-negative, rs2 = −1): DIV gives rs1; REM gives 0.
  - → DONE.
- **DONE**
  - `out_valid`=1; outputs stay stable while `out_ready`=0.
  - On `out_ready`=1 → IDLE.
- **Handshake**
  - `in_ready` = (state==IDLE) & ~`flush` & `rst_n`.
  - `out_valid` = (state==DONE).
  - No back-to-back overlap: the next op is accepted no earlier than the cycle after the result is taken.
- **`flush`**
  - Any state → IDLE next edge, and `out_valid` drops.
  - A request presented in the flush cycle is not accepted.
  - `flush` has priority over a simultaneous `out_ready`.
- **Reset**
  - `rst_n` low → IDLE from any state, including mid-divide.
  - Reset values: `in_ready`=0 during reset and 1 on the first cycle after.
  - `out_valid`, `out_result`, `out_rd`, `out_illegal`, `busy` and counters all reset to 0.

## Timing
- MUL: accepted at edge N; `out_valid` high from edge N+`MUL_LATENCY`+1.
- DIV normal: `out_valid` from edge N+XLEN+2, i.e. 34 cycles for XLEN=32.
  - Cycle N+1 loads the magnitudes and flags special cases.
  - Then XLEN iterations.
  - Then one fixup cycle.
- DIV special case or illegal op: `out_valid` from edge N+2.
- Result taken at edge M; `in_ready` high in cycle M+1.
- No combinational path from `in_*` to `out_*`. `out_ready` → `in_ready` is registered through the state.

## Configuration
- `MULDIV_DIV_EARLY_OUT_EN` defined:
  - In DIV, the leading zeros of the unsigned dividend skip iterations. The shift register is pre-aligned and the counter loaded with the dividend's significant bit count.
  - A dividend < 2 completes in 3 cycles; latency = (bits-needed)+2.
- Undefined: fixed XLEN-iteration latency, as in Timing.
- Results are identical either way.

## Structure
- Add to `rv32_pkg`:
  - `muldiv_state_t` enum (IDLE, MUL, DIV, DONE).
  - `is_muldiv_op()` function.
  - Result-select constants.
- The ALU_OP_* codes are reused unchanged.
- One sub-module, `iterative_divider`: magnitudes in, start/done, quotient and remainder out, owns the counter and the early-out logic. Sign handling and special cases stay in the parent.
- The multiplier is an inline retiming register chain of depth `MUL_LATENCY`.

## Test plan
- MUL with rs1=0xFFFFFFFF, rs2=0xFFFFFFFF, `MUL_LATENCY`=2:
  - MUL → 0x00000001, MULHU → 0xFFFFFFFE, MULH → 0x00000000, MULHSU → 0xFFFFFFFF.
  - `out_valid` exactly 3 cycles after the transfer.
- DIV with rs1=−7, rs2=2 → −3 (0xFFFFFFFD). REM → −1. DIVU of 0xFFFFFFF9/2 → 0x7FFFFFFC. Latency 34 with the macro undefined.
- Divide by zero and overflow:
  - DIVU x/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000; REM → 0.
  - All in 2 cycles.
- Backpressure: hold `out_ready`=0 for 10 cycles → `out_result` and `out_rd` stable, `in_ready`=0. Release → `in_ready`=1 on the next cycle.
- `flush` on iteration 5 of a DIV → `out_valid` never rises. The next MUL 3×4 returns 12 with correct rd.
- Reset mid-MUL, and an illegal op ADD → `out_illegal`=1, result 0, latency 2.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 ALU opcode map plus the types and helpers used by
// the multi-cycle M-extension unit.
//   ALU_OP_*        6-bit ALU operation codes (execute-stage encoding)
//   muldiv_state_t  muldiv FSM state (IDLE, MUL, DIV, DONE)
//   RES_*           result-select codes (which half/part of a result to return)
//   is_muldiv_op()  true for MUL..REMU
//   result_sel()    maps an M op onto its result-select code
package rv32_pkg;

  localparam logic [5:0] ALU_OP_ADD    = 6'd0;
  localparam logic [5:0] ALU_OP_SUB    = 6'd1;
  localparam logic [5:0] ALU_OP_AND    = 6'd2;
  localparam logic [5:0] ALU_OP_OR     = 6'd3;
  localparam logic [5:0] ALU_OP_XOR    = 6'd4;
  localparam logic [5:0] ALU_OP_SLL    = 6'd5;
  localparam logic [5:0] ALU_OP_SRL    = 6'd6;
  localparam logic [5:0] ALU_OP_SRA    = 6'd7;
  localparam logic [5:0] ALU_OP_SLT    = 6'd8;
  localparam logic [5:0] ALU_OP_SLTU   = 6'd9;
  localparam logic [5:0] ALU_OP_MUL    = 6'd16;
  localparam logic [5:0] ALU_OP_MULH   = 6'd17;
  localparam logic [5:0] ALU_OP_MULHSU = 6'd18;
  localparam logic [5:0] ALU_OP_MULHU  = 6'd19;
  localparam logic [5:0] ALU_OP_DIV    = 6'd20;
  localparam logic [5:0] ALU_OP_DIVU   = 6'd21;
  localparam logic [5:0] ALU_OP_REM    = 6'd22;
  localparam logic [5:0] ALU_OP_REMU   = 6'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam logic [1:0] RES_MUL_LO = 2'd0;
  localparam logic [1:0] RES_MUL_HI = 2'd1;
  localparam logic [1:0] RES_DIV_Q  = 2'd2;
  localparam logic [1:0] RES_DIV_R  = 2'd3;

  function automatic logic is_muldiv_op(input logic [5:0] op);
    return (op >= ALU_OP_MUL) && (op <= ALU_OP_REMU);
  endfunction

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op >= ALU_OP_MUL) && (op <= ALU_OP_MULHU);
  endfunction

  function automatic logic [1:0] result_sel(input logic [5:0] op);
    logic [1:0] sel;
    case (op)
      ALU_OP_MUL:                          sel = RES_MUL_LO;
      ALU_OP_MULH, ALU_OP_MULHSU,
      ALU_OP_MULHU:                        sel = RES_MUL_HI;
      ALU_OP_DIV, ALU_OP_DIVU:             sel = RES_DIV_Q;
      default:                             sel = RES_DIV_R;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_muldiv_unit_divider.sv
// iterative_divider: unsigned restoring radix-2 divider, one quotient bit
// per cycle. Operands are magnitudes; sign handling lives in the parent.
// Optional macro MULDIV_DIV_EARLY_OUT_EN: skip the dividend's leading zeros.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   abort                drop the running division
//   start                load dividend/divisor and begin
//   dividend, divisor    XLEN-bit unsigned magnitudes
//   done                 quotient/remainder valid (level, until next start)
//   quotient, remainder  XLEN-bit unsigned results
module iterative_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [CW-1:0]   cnt;
  logic            active;

  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;
  logic            fits;

`ifdef MULDIV_DIV_EARLY_OUT_EN
  // Number of significant dividend bits, at least 1.
  function automatic logic [CW-1:0] sig_bits(input logic [XLEN-1:0] v);
    logic [CW-1:0] n;
    n = CW'(1);
    for (int unsigned i = 1; i < XLEN; i++) begin
      if (v[i]) n = CW'(i + 1);
    end
    return n;
  endfunction

  logic [CW-1:0] load_bits;
  logic [CW-1:0] load_shift;
  assign load_bits  = sig_bits(dividend);
  assign load_shift = CW'(XLEN) - load_bits;
`endif

  // Shift the next dividend bit into the partial remainder and try to subtract.
  always_comb begin
    trial = {rem, quo[XLEN-1]};
    diff  = trial - {1'b0, dvs};
    fits  = trial >= {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      rem    <= '0;
      dvs    <= divisor;
      active <= 1'b1;
`ifdef MULDIV_DIV_EARLY_OUT_EN
      // Pre-align so the first iteration sees the dividend's top set bit.
      quo    <= dividend << load_shift;
      cnt    <= load_bits;
`else
      quo    <= dividend;
      cnt    <= CW'(XLEN);
`endif
    end else if (active && (cnt != '0)) begin
      if (fits) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
    end
  end

  assign done      = active && (cnt == '0);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/multicycle_muldiv_unit.sv
// multicycle_muldiv_unit: RV32M multiply/divide unit beside the execute ALU.
// Pipelined multiplier (MUL_LATENCY retiming stages) and an iterative
// restoring divider (iterative_divider). Optional macro
// MULDIV_DIV_EARLY_OUT_EN enables divider early-out (results unchanged).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             kill in-flight op and any held result
//   in_valid/in_ready request handshake; in_alu_op, in_rs1, in_rs2, in_rd
//   out_valid/out_ready result handshake; out_result, out_rd, out_illegal
//   busy              FSM not idle
module multicycle_muldiv_unit
  import rv32_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_alu_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic            busy
);

  localparam int MCW = $clog2(MUL_LATENCY + 1);

  muldiv_state_t   state;
  logic [5:0]      op_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [4:0]      rd_q;
  logic            illegal_q;
  logic            div_wait;
  logic [MCW-1:0]  mul_cnt;

  // ---------------- multiplier ----------------
  logic             mul_a_signed;
  logic             mul_b_signed;
  logic [2*XLEN-1:0] mul_a_ext;
  logic [2*XLEN-1:0] mul_b_ext;
  logic [2*XLEN-1:0] mul_pipe [MUL_LATENCY];
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    mul_a_signed = (op_q == ALU_OP_MULH) || (op_q == ALU_OP_MULHSU);
    mul_b_signed = (op_q == ALU_OP_MULH);
    // Low 2*XLEN bits of the extended product are the exact signed/unsigned product.
    mul_a_ext = {{XLEN{mul_a_signed & rs1_q[XLEN-1]}}, rs1_q};
    mul_b_ext = {{XLEN{mul_b_signed & rs2_q[XLEN-1]}}, rs2_q};
  end

  always_ff @(posedge clk) begin
    mul_pipe[0] <= mul_a_ext * mul_b_ext;
    for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
      mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  assign mul_res = (result_sel(op_q) == RES_MUL_HI) ? mul_pipe[MUL_LATENCY-1][2*XLEN-1:XLEN]
                                                    : mul_pipe[MUL_LATENCY-1][XLEN-1:0];

  // ---------------- divider ----------------
  logic            signed_div;
  logic            is_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_by_zero;
  logic            div_overflow;
  logic            div_special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] div_res;
  logic            div_start;
  logic            div_done;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] most_neg;

  always_comb begin
    most_neg     = '0;
    most_neg[XLEN-1] = 1'b1;
    signed_div   = (op_q == ALU_OP_DIV) || (op_q == ALU_OP_REM);
    is_rem       = (result_sel(op_q) == RES_DIV_R);
    a_neg        = signed_div & rs1_q[XLEN-1];
    b_neg        = signed_div & rs2_q[XLEN-1];
    mag_a        = a_neg ? (~rs1_q + XLEN'(1)) : rs1_q;
    mag_b        = b_neg ? (~rs2_q + XLEN'(1)) : rs2_q;
    div_by_zero  = (rs2_q == '0);
    div_overflow = signed_div && (rs1_q == most_neg) && (rs2_q == '1);
    div_special  = div_by_zero || div_overflow;
    if (div_by_zero) special_res = is_rem ? rs1_q : '1;
    else             special_res = is_rem ? '0 : rs1_q;
    if (is_rem) div_res = a_neg ? (~div_rem + XLEN'(1)) : div_rem;
    else        div_res = (a_neg ^ b_neg) ? (~div_quo + XLEN'(1)) : div_quo;
  end

  assign div_start = (state == DIV) && !div_wait && !illegal_q && !div_special;

  iterative_divider #(
    .XLEN (XLEN)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (flush),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // ---------------- control ----------------
  assign in_ready  = (state == IDLE) && !flush && rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
      div_wait    <= 1'b0;
      mul_cnt     <= '0;
      out_result  <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      div_wait <= 1'b0;
      mul_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q      <= in_alu_op;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            rd_q      <= in_rd;
            illegal_q <= !is_muldiv_op(in_alu_op);
            mul_cnt   <= '0;
            div_wait  <= 1'b0;
            // Illegal ops share the divider's one-cycle special-case slot.
            state     <= is_mul_op(in_alu_op) ? MUL : DIV;
          end
        end
        MUL: begin
          if (mul_cnt == MCW'(MUL_LATENCY)) begin
            state       <= DONE;
            out_result  <= mul_res;
            out_rd      <= rd_q;
            out_illegal <= 1'b0;
          end else begin
            mul_cnt <= mul_cnt + MCW'(1);
          end
        end
        DIV: begin
          if (!div_wait) begin
            div_wait <= 1'b1;
          end else if (illegal_q) begin
            state       <= DONE;
            out_result  <= '0;
            out_rd      <= rd_q;
            out_illegal <= 1'b1;
          end else if (div_special) begin
            state       <= DONE;
            out_result  <= special_res;
            out_rd      <= rd_q;
            out_illegal <= 1'b0;
          end else if (div_done) begin
            state       <= DONE;
            out_result  <= div_res;
            out_rd      <= rd_q;
            out_illegal <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state    <= IDLE;
            div_wait <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_muldiv_unit.sv
// Directed testbench for multicycle_muldiv_unit (XLEN=32, MUL_LATENCY=2).
module tb_multicycle_muldiv_unit;
  import rv32_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_alu_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        busy;

  int compared;
  int mismatched;

  multicycle_muldiv_unit #(
    .XLEN        (32),
    .MUL_LATENCY (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_op   (in_alu_op),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request, transfer it, and wait (bounded) for out_valid.
  // lat = edges from transfer to out_valid; -1 on timeout, -2 if not accepted.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat);
    @(negedge clk);
    in_alu_op = op;
    in_rs1    = a;
    in_rs2    = b;
    in_rd     = rd;
    in_valid  = 1'b1;
    if (in_ready !== 1'b1) begin
      in_valid = 1'b0;
      lat = -2;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0 ||
        out_rd !== 5'd0 || out_illegal !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%h rd=%0d illegal=%b, need 0 0 0 0 0 0",
               in_ready, out_valid, busy, out_result, out_rd, out_illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
  endtask

  task automatic test_mul();
    logic [5:0]  ops [4];
    logic [31:0] exp [4];
    int lat;
    ops[0] = ALU_OP_MUL;    exp[0] = 32'h00000001;
    ops[1] = ALU_OP_MULHU;  exp[1] = 32'hFFFFFFFE;
    ops[2] = ALU_OP_MULH;   exp[2] = 32'h00000000;
    ops[3] = ALU_OP_MULHSU; exp[3] = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(i + 1), lat);
      compared++;
      if (out_result !== exp[i] || out_rd !== 5'(i + 1) || out_illegal !== 1'b0) begin
        mismatched++;
        $display("FAIL mul_%0d: result=%h rd=%0d illegal=%b need %h %0d 0",
                 i, out_result, out_rd, out_illegal, exp[i], i + 1);
      end
      compared++;
      if (lat != 3) begin
        mismatched++;
        $display("FAIL mul_latency_%0d: got %0d need 3", i, lat);
      end
      take_result();
    end
  endtask

  task automatic test_div();
    logic [5:0]  ops [6];
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [31:0] exp [6];
    int          exp_lat [6];
    int lat;
    ops[0] = ALU_OP_DIV;  a[0] = 32'hFFFFFFF9; b[0] = 32'd2;        exp[0] = 32'hFFFFFFFD;
    ops[1] = ALU_OP_REM;  a[1] = 32'hFFFFFFF9; b[1] = 32'd2;        exp[1] = 32'hFFFFFFFF;
    ops[2] = ALU_OP_DIVU; a[2] = 32'hFFFFFFF9; b[2] = 32'd2;        exp[2] = 32'h7FFFFFFC;
    ops[3] = ALU_OP_REMU; a[3] = 32'd100;      b[3] = 32'd7;        exp[3] = 32'd2;
    ops[4] = ALU_OP_DIV;  a[4] = 32'd100;      b[4] = 32'hFFFFFFF9; exp[4] = 32'hFFFFFFF2;
    ops[5] = ALU_OP_REM;  a[5] = 32'd100;      b[5] = 32'hFFFFFFF9; exp[5] = 32'd2;
`ifdef MULDIV_DIV_EARLY_OUT_EN
    exp_lat[0] = 5; exp_lat[1] = 5; exp_lat[2] = 34;
    exp_lat[3] = 9; exp_lat[4] = 9; exp_lat[5] = 9;
`else
    for (int i = 0; i < 6; i++) exp_lat[i] = 34;
`endif
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], a[i], b[i], 5'(10 + i), lat);
      compared++;
      if (out_result !== exp[i] || out_rd !== 5'(10 + i)) begin
        mismatched++;
        $display("FAIL div_%0d: result=%h rd=%0d need %h %0d", i, out_result, out_rd, exp[i], 10 + i);
      end
      compared++;
      if (lat != exp_lat[i]) begin
        mismatched++;
        $display("FAIL div_latency_%0d: got %0d need %0d", i, lat, exp_lat[i]);
      end
      take_result();
    end
  endtask

  task automatic test_special();
    logic [5:0]  ops [6];
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [31:0] exp [6];
    int lat;
    ops[0] = ALU_OP_DIVU; a[0] = 32'h00001234; b[0] = 32'h0;        exp[0] = 32'hFFFFFFFF;
    ops[1] = ALU_OP_REMU; a[1] = 32'd5;        b[1] = 32'h0;        exp[1] = 32'd5;
    ops[2] = ALU_OP_DIV;  a[2] = 32'h80000000; b[2] = 32'hFFFFFFFF; exp[2] = 32'h80000000;
    ops[3] = ALU_OP_REM;  a[3] = 32'h80000000; b[3] = 32'hFFFFFFFF; exp[3] = 32'h0;
    ops[4] = ALU_OP_DIV;  a[4] = 32'd7;        b[4] = 32'h0;        exp[4] = 32'hFFFFFFFF;
    ops[5] = ALU_OP_REM;  a[5] = 32'hFFFFFFF9; b[5] = 32'h0;        exp[5] = 32'hFFFFFFF9;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], a[i], b[i], 5'(20 + i), lat);
      compared++;
      if (out_result !== exp[i] || lat != 2) begin
        mismatched++;
        $display("FAIL special_%0d: result=%h latency=%0d need %h 2", i, out_result, lat, exp[i]);
      end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run_op(ALU_OP_MUL, 32'd6, 32'd7, 5'd9, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_result !== 32'd42 || out_rd !== 5'd9 || in_ready !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0 || lat != 3) begin
      mismatched++;
      $display("FAIL backpressure_hold: %0d unstable cycles, latency %0d; need 0 and 3 (result=%h rd=%0d)",
               bad, lat, out_result, out_rd);
    end
    @(negedge clk);
    out_ready = 1'b1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_ready_comb: in_ready=%b need 0 before edge", in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    @(negedge clk);
    in_alu_op = ALU_OP_DIVU;
    in_rs1    = 32'd1000;
    in_rs2    = 32'd3;
    in_rd     = 5'd4;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_alu_op = ALU_OP_MUL;
    in_rs1    = 32'd9;
    in_rs2    = 32'd9;
    in_rd     = 5'd30;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_in_ready: got %b need 0", in_ready);
    end
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    compared++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_idle: busy=%b out_valid=%b need 0 0", busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    compared++;
    if (seen != 0) begin
      mismatched++;
      $display("FAIL flush_no_result: active for %0d cycles need 0", seen);
    end
    run_op(ALU_OP_MUL, 32'd3, 32'd4, 5'd17, lat);
    compared++;
    if (out_result !== 32'd12 || out_rd !== 5'd17 || lat != 3) begin
      mismatched++;
      $display("FAIL flush_next_mul: result=%h rd=%0d latency=%0d need c 17 3", out_result, out_rd, lat);
    end
    take_result();
  endtask

  task automatic test_reset_mid_mul_and_illegal();
    int lat;
    @(negedge clk);
    in_alu_op = ALU_OP_MUL;
    in_rs1    = 32'd5;
    in_rs2    = 32'd5;
    in_rd     = 5'd6;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_result !== 32'h0 || out_rd !== 5'd0) begin
      mismatched++;
      $display("FAIL reset_mid_mul: busy=%b out_valid=%b in_ready=%b result=%h rd=%0d need 0 0 0 0 0",
               busy, out_valid, in_ready, out_result, out_rd);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        compared++;
        mismatched++;
        $display("FAIL reset_hold: out_valid=1 during reset need 0");
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(ALU_OP_ADD, 32'd1, 32'd2, 5'd3, lat);
    compared++;
    if (out_illegal !== 1'b1 || out_result !== 32'h0 || out_rd !== 5'd3 || lat != 2) begin
      mismatched++;
      $display("FAIL illegal_op: illegal=%b result=%h rd=%0d latency=%0d need 1 0 3 2",
               out_illegal, out_result, out_rd, lat);
    end
    take_result();
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL illegal_release: out_valid=%b in_ready=%b need 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_alu_op  = '0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_rd      = '0;
    out_ready  = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid_mul_and_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
